// File: rtl/deserializer_pkg.sv
// Shared constants and helpers for the serial link blocks (deserializer, serializer).
package deserializer_pkg;

  localparam int unsigned DATA_W_DEF = 16;

  // Bit-counter width for a word of w bits; the serializer sizes its counter the same way.
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/deserializer.sv
// Bit-serial to parallel converter: collects DATA_W valid bits, MSB first, and presents the
// assembled word with a one-cycle valid pulse. Word alignment is the count of valid bits
// since reset; there is no framing input.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              data_i,
  input  logic              data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic              deser_data_val_o
);

  localparam int unsigned CntW = cnt_w(DATA_W);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] word_next;
  logic              word_done;

  // The oldest shifted-in bit is never needed: the word is taken from the low bits plus the
  // bit arriving on the completing cycle.
  logic shreg_msb_unused;
  assign shreg_msb_unused = shreg_q[DATA_W-1];

  // Word completes when the valid bit arrives while the counter sits on its last slot.
  always_comb begin
    word_done = data_val_i && (cnt_q == CntLast);
    word_next = {shreg_q[DATA_W-2:0], data_i};
  end

  // Bit counter and shift register; both advance only on valid cycles so data_i is a
  // don't-care (even X/Z) during gaps.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (data_val_i) begin
      shreg_q <= word_next;
      cnt_q   <= word_done ? '0 : cnt_q + CntW'(1);
    end
  end

  // Output register: the word updates only on completion and holds between words.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      deser_data_o     <= '0;
      deser_data_val_o <= 1'b0;
    end else begin
      deser_data_val_o <= word_done;
      if (word_done) begin
        deser_data_o <= word_next;
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: a 16-bit and an 8-bit instance share one serial
// stream and are compared every cycle against a queue-based model of the link.
module tb_deserializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_i = 1'b0;
  logic        data_val_i = 1'b0;
  logic [15:0] d16;
  logic        v16;
  logic [7:0]  d8;
  logic        v8;

  always #5 clk = ~clk;

  deserializer #(.DATA_W(16)) dut16 (
    .clk_i           (clk),
    .rst_i           (rst),
    .data_i          (data_i),
    .data_val_i      (data_val_i),
    .deser_data_o    (d16),
    .deser_data_val_o(v16)
  );

  deserializer #(.DATA_W(8)) dut8 (
    .clk_i           (clk),
    .rst_i           (rst),
    .data_i          (data_i),
    .data_val_i      (data_val_i),
    .deser_data_o    (d8),
    .deser_data_val_o(v8)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // First received bit ends up most significant.
  function automatic logic [63:0] pack(input bit q[$]);
    logic [63:0] r = '0;
    foreach (q[i]) r = (r << 1) | 64'(q[i]);
    return r;
  endfunction

  // Model: every valid bit joins a list; a full list becomes the next word, visible one
  // cycle after the completing bit.
  bit          q16[$];
  bit          q8[$];
  logic [15:0] p_d16 = '0;
  logic        p_v16 = 1'b0;
  logic [7:0]  p_d8 = '0;
  logic        p_v8 = 1'b0;
  int          cyc = 0;
  logic [15:0] seen16[$];
  int          per16[$];
  logic [7:0]  seen8[$];
  int          per8[$];

  // Compare DUT against model on the falling edge, then advance the model with the inputs
  // the next rising edge will sample.
  always @(negedge clk) begin
    logic [63:0] w;
    if (rst) begin
      q16.delete();
      q8.delete();
      p_d16 = '0;
      p_v16 = 1'b0;
      p_d8  = '0;
      p_v8  = 1'b0;
    end
    check("data16", 64'(d16), 64'(p_d16));
    check("val16", 64'(v16), 64'(p_v16));
    check("data8", 64'(d8), 64'(p_d8));
    check("val8", 64'(v8), 64'(p_v8));
    if (v16) begin
      seen16.push_back(d16);
      per16.push_back(cyc);
    end
    if (v8) begin
      seen8.push_back(d8);
      per8.push_back(cyc);
    end
    if (!rst) begin
      p_v16 = 1'b0;
      p_v8  = 1'b0;
      if (data_val_i) begin
        q16.push_back(data_i);
        q8.push_back(data_i);
        if (q16.size() == 16) begin
          w = pack(q16);
          p_d16 = w[15:0];
          p_v16 = 1'b1;
          q16.delete();
        end
        if (q8.size() == 8) begin
          w = pack(q8);
          p_d8 = w[7:0];
          p_v8 = 1'b1;
          q8.delete();
        end
      end
    end
    cyc++;
  end

  task automatic drive(input logic b, input logic v);
    @(posedge clk);
    #1;
    data_i     = b;
    data_val_i = v;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'bx, 1'b0);
  endtask

  task automatic send(input logic [15:0] w, input int nb, input bit gaps);
    for (int i = nb - 1; i >= 0; i--) begin
      drive(w[i], 1'b1);
      if (gaps) idle(int'($urandom_range(1, 4)));
    end
  endtask

  task automatic clear_seen();
    seen16.delete();
    per16.delete();
    seen8.delete();
    per8.delete();
  endtask

  int          start;
  logic [15:0] sent[$];
  logic [15:0] rw;

  initial begin
    idle(3);
    rst = 1'b0;

    // Continuous word, then hold through idle cycles.
    idle(1);
    clear_seen();
    start = cyc + 1;
    send(16'hA5C3, 16, 1'b0);
    idle(6);
    check("t1_pulses", 64'(seen16.size()), 64'd1);
    if (seen16.size() >= 1) begin
      check("t1_word", 64'(seen16[0]), 64'hA5C3);
      check("t1_latency", 64'(per16[0] - start), 64'd16);
    end
    check("t1_hold", 64'(d16), 64'hA5C3);
    check("t1_model", 64'(p_d16), 64'hA5C3);

    // Gaps with X on data_i between every bit.
    clear_seen();
    send(16'h1234, 16, 1'b1);
    idle(2);
    check("t2_pulses", 64'(seen16.size()), 64'd1);
    if (seen16.size() >= 1) check("t2_word", 64'(seen16[0]), 64'h1234);

    // Back-to-back words.
    idle(1);
    clear_seen();
    start = cyc + 1;
    send(16'hFFFF, 16, 1'b0);
    send(16'h0000, 16, 1'b0);
    send(16'h8001, 16, 1'b0);
    idle(2);
    check("t3_pulses", 64'(seen16.size()), 64'd3);
    if (seen16.size() == 3) begin
      check("t3_w0", 64'(seen16[0]), 64'hFFFF);
      check("t3_w1", 64'(seen16[1]), 64'h0000);
      check("t3_w2", 64'(seen16[2]), 64'h8001);
      check("t3_p0", 64'(per16[0] - start), 64'd16);
      check("t3_p1", 64'(per16[1] - start), 64'd32);
      check("t3_p2", 64'(per16[2] - start), 64'd48);
    end

    // Mid-word asynchronous reset discards the partial word.
    send(16'h005B, 7, 1'b0);
    @(posedge clk);
    #3;
    rst        = 1'b1;
    data_val_i = 1'b0;
    #1;
    check("t4_rst_d16", 64'(d16), 64'd0);
    check("t4_rst_v16", 64'(v16), 64'd0);
    check("t4_rst_d8", 64'(d8), 64'd0);
    idle(2);
    rst = 1'b0;
    clear_seen();
    send(16'hBEEF, 16, 1'b0);
    idle(2);
    check("t4_pulses", 64'(seen16.size()), 64'd1);
    if (seen16.size() >= 1) check("t4_word", 64'(seen16[0]), 64'hBEEF);

    // 8-bit instance: two words.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    clear_seen();
    start = cyc + 1;
    send(16'h5AC3, 16, 1'b0);
    idle(2);
    check("t5_pulses", 64'(seen8.size()), 64'd2);
    if (seen8.size() == 2) begin
      check("t5_w0", 64'(seen8[0]), 64'h5A);
      check("t5_w1", 64'(seen8[1]), 64'hC3);
      check("t5_p0", 64'(per8[0] - start), 64'd8);
      check("t5_p1", 64'(per8[1] - start), 64'd16);
    end

    // Random words with random gap patterns, as a serializer link would deliver them.
    clear_seen();
    sent.delete();
    for (int k = 0; k < 20; k++) begin
      rw = 16'($urandom);
      sent.push_back(rw);
      send(rw, 16, bit'($urandom_range(0, 1)));
    end
    idle(2);
    check("t6_pulses", 64'(seen16.size()), 64'd20);
    for (int k = 0; k < 20 && k < seen16.size(); k++) begin
      check($sformatf("t6_w%0d", k), 64'(seen16[k]), 64'(sent[k]));
    end

    // Free-running random stream, checked cycle by cycle.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
